// File: rtl/celiskisiz_yurut_pkg.sv
// Shared encodings for the execute stage: operation codes, branch conditions,
// instruction types and execute-FSM states.
package celiskisiz_yurut_pkg;

   typedef enum logic [3:0] {
      ISLEM_ADD   = 4'd0,
      ISLEM_SUB   = 4'd1,
      ISLEM_AND   = 4'd2,
      ISLEM_OR    = 4'd3,
      ISLEM_XOR   = 4'd4,
      ISLEM_SLL   = 4'd5,
      ISLEM_SRL   = 4'd6,
      ISLEM_SRA   = 4'd7,
      ISLEM_SLT   = 4'd8,
      ISLEM_SLTU  = 4'd9,
      ISLEM_MUL   = 4'd10,
      ISLEM_MULHU = 4'd11,
      ISLEM_DIVU  = 4'd12,
      ISLEM_REMU  = 4'd13
   } islem_e;

   typedef enum logic [2:0] {
      DAL_EQ  = 3'd0,
      DAL_NE  = 3'd1,
      DAL_LT  = 3'd2,
      DAL_GE  = 3'd3,
      DAL_LTU = 3'd4,
      DAL_GEU = 3'd5,
      DAL_YOK = 3'd6
   } dal_e;

   typedef enum logic [1:0] {
      TIP_J     = 2'd0,
      TIP_B     = 2'd1,
      TIP_DIGER = 2'd2
   } tip_e;

   typedef enum logic [1:0] {
      BOSTA = 2'd0,
      CALIS = 2'd1,
      BITTI = 2'd2
   } durum_e;

   function automatic logic cok_cevrimli(input logic [3:0] islem);
      return (islem == ISLEM_MUL) || (islem == ISLEM_MULHU) ||
             (islem == ISLEM_DIVU) || (islem == ISLEM_REMU);
   endfunction

endpackage

// File: rtl/yineli_carp_bol.sv
// Iterative unsigned multiplier / restoring divider, one bit per cycle.
// ust/alt hold {product-high, product-low} or {remainder, quotient}.
module yineli_carp_bol
   import celiskisiz_yurut_pkg::*;
#(
   parameter int VERI_BIT  = 32,
   parameter int SAYAC_BIT = $clog2(VERI_BIT) + 1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                basla,
   input  logic                iptal,
   input  logic [3:0]          islem,
   input  logic [VERI_BIT-1:0] deger1,
   input  logic [VERI_BIT-1:0] deger2,
   output logic                bitti,
   output logic [VERI_BIT-1:0] sonuc
);
   localparam logic [SAYAC_BIT-1:0] SON_ADIM = SAYAC_BIT'(VERI_BIT - 1);

   logic [VERI_BIT-1:0]  ust_q, ust_d, alt_q, alt_d, ek_q, ek_d;
   logic [3:0]           islem_q, islem_d;
   logic [SAYAC_BIT-1:0] sayac_q, sayac_d;
   logic                 mesgul_q, mesgul_d;
   logic                 bolme;
   logic [VERI_BIT:0]    toplam, kalan;
   logic [VERI_BIT-1:0]  fark;

   assign bolme = (islem_q == ISLEM_DIVU) || (islem_q == ISLEM_REMU);
   // High when the step being performed this cycle is the last one.
   assign bitti = mesgul_q && (sayac_q == SON_ADIM);
   assign sonuc = ((islem_q == ISLEM_MULHU) || (islem_q == ISLEM_REMU)) ? ust_q : alt_q;

   always_comb begin
      toplam   = {1'b0, ust_q} + (alt_q[0] ? {1'b0, ek_q} : '0);
      kalan    = {ust_q, alt_q[VERI_BIT-1]};
      fark     = kalan[VERI_BIT-1:0] - ek_q;
      ust_d    = ust_q;
      alt_d    = alt_q;
      ek_d     = ek_q;
      islem_d  = islem_q;
      sayac_d  = sayac_q;
      mesgul_d = mesgul_q;
      if (iptal) begin
         mesgul_d = 1'b0;
      end else if (basla) begin
         ust_d    = '0;
         alt_d    = deger1;
         ek_d     = deger2;
         islem_d  = islem;
         sayac_d  = '0;
         mesgul_d = 1'b1;
      end else if (mesgul_q) begin
         if (bolme) begin
            // A zero divisor always "fits", giving all-ones quotient and dividend remainder.
            if (kalan >= {1'b0, ek_q}) begin
               ust_d = fark;
               alt_d = {alt_q[VERI_BIT-2:0], 1'b1};
            end else begin
               ust_d = kalan[VERI_BIT-1:0];
               alt_d = {alt_q[VERI_BIT-2:0], 1'b0};
            end
         end else begin
            ust_d = toplam[VERI_BIT:1];
            alt_d = {toplam[0], alt_q[VERI_BIT-1:1]};
         end
         sayac_d = sayac_q + 1'b1;
         if (bitti) mesgul_d = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ust_q    <= '0;
         alt_q    <= '0;
         ek_q     <= '0;
         islem_q  <= '0;
         sayac_q  <= '0;
         mesgul_q <= 1'b0;
      end else begin
         ust_q    <= ust_d;
         alt_q    <= alt_d;
         ek_q     <= ek_d;
         islem_q  <= islem_d;
         sayac_q  <= sayac_d;
         mesgul_q <= mesgul_d;
      end
   end

endmodule

// File: rtl/celiskisiz_yurut.sv
// Execute stage: single-cycle ALU, branch resolution and an iterative
// multiply/divide unit that stalls upstream while it runs.
module celiskisiz_yurut
   import celiskisiz_yurut_pkg::*;
#(
   parameter int VERI_BIT  = 32,
   parameter int SAYAC_BIT = $clog2(VERI_BIT) + 1
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                gecerli_i,
   input  logic [3:0]          islem_i,
   input  logic [VERI_BIT-1:0] deger1_i,
   input  logic [VERI_BIT-1:0] deger2_i,
   input  logic [2:0]          dal_i,
   input  logic [1:0]          buyruk_tipi_i,
   input  logic [4:0]          rd_adres_i,
   input  logic                yaz_yazmac_i,
   input  logic                bosalt_i,
   output logic                durdur_o,
   output logic [VERI_BIT-1:0] program_sayaci_o,
   output logic                program_sayaci_guncelle_o,
   output logic                gecerli_o,
   output logic                yaz_yazmac_o,
   output logic [4:0]          rd_adres_o,
   output logic [VERI_BIT-1:0] rd_deger_o
);
   localparam int KAYMA_BIT = $clog2(VERI_BIT);

   durum_e              durum_q, durum_d;
   logic                gecerli_q, gecerli_d;
   logic                yaz_q, yaz_d;
   logic [4:0]          rd_adres_q, rd_adres_d;
   logic [VERI_BIT-1:0] rd_deger_q, rd_deger_d;
   logic [4:0]          bekleyen_rd_q, bekleyen_rd_d;
   logic                bekleyen_yaz_q, bekleyen_yaz_d;

   logic [KAYMA_BIT-1:0] kayma;
   logic                 cok_cevrim, dal_dogru, basla, bitti;
   logic [VERI_BIT-1:0]  alu_sonuc, carp_bol_sonuc;

   assign kayma      = deger2_i[KAYMA_BIT-1:0];
   assign cok_cevrim = cok_cevrimli(islem_i);

   always_comb begin
      alu_sonuc = '0;
      case (islem_i)
         ISLEM_ADD:  alu_sonuc = deger1_i + deger2_i;
         ISLEM_SUB:  alu_sonuc = deger1_i - deger2_i;
         ISLEM_AND:  alu_sonuc = deger1_i & deger2_i;
         ISLEM_OR:   alu_sonuc = deger1_i | deger2_i;
         ISLEM_XOR:  alu_sonuc = deger1_i ^ deger2_i;
         ISLEM_SLL:  alu_sonuc = deger1_i << kayma;
         ISLEM_SRL:  alu_sonuc = deger1_i >> kayma;
         ISLEM_SRA:  alu_sonuc = $signed(deger1_i) >>> kayma;
         ISLEM_SLT:  alu_sonuc = {{(VERI_BIT-1){1'b0}}, $signed(deger1_i) < $signed(deger2_i)};
         ISLEM_SLTU: alu_sonuc = {{(VERI_BIT-1){1'b0}}, deger1_i < deger2_i};
         default:    alu_sonuc = '0;
      endcase
   end

   always_comb begin
      dal_dogru = 1'b0;
      case (dal_i)
         DAL_EQ:  dal_dogru = (deger1_i == deger2_i);
         DAL_NE:  dal_dogru = (deger1_i != deger2_i);
         DAL_LT:  dal_dogru = ($signed(deger1_i) <  $signed(deger2_i));
         DAL_GE:  dal_dogru = ($signed(deger1_i) >= $signed(deger2_i));
         DAL_LTU: dal_dogru = (deger1_i <  deger2_i);
         DAL_GEU: dal_dogru = (deger1_i >= deger2_i);
         default: dal_dogru = 1'b0;
      endcase
   end

   assign program_sayaci_o          = deger1_i + deger2_i;
   assign program_sayaci_guncelle_o = gecerli_i && (durum_q == BOSTA) &&
                                      ((buyruk_tipi_i == TIP_J) ||
                                       ((buyruk_tipi_i == TIP_B) && dal_dogru));
   // Combinational so the accepting cycle itself already holds upstream.
   assign durdur_o = !rst_i && !bosalt_i &&
                     ((durum_q == CALIS) || ((durum_q == BOSTA) && gecerli_i && cok_cevrim));

   always_comb begin
      durum_d        = durum_q;
      gecerli_d      = 1'b0;
      yaz_d          = yaz_q;
      rd_adres_d     = rd_adres_q;
      rd_deger_d     = rd_deger_q;
      bekleyen_rd_d  = bekleyen_rd_q;
      bekleyen_yaz_d = bekleyen_yaz_q;
      basla          = 1'b0;
      if (bosalt_i) begin
         durum_d = BOSTA;
         yaz_d   = 1'b0;
      end else begin
         case (durum_q)
            BOSTA: begin
               if (gecerli_i) begin
                  if (cok_cevrim) begin
                     basla          = 1'b1;
                     bekleyen_rd_d  = rd_adres_i;
                     bekleyen_yaz_d = yaz_yazmac_i;
                     durum_d        = CALIS;
                  end else begin
                     gecerli_d  = 1'b1;
                     yaz_d      = yaz_yazmac_i;
                     rd_adres_d = rd_adres_i;
                     rd_deger_d = alu_sonuc;
                  end
               end
            end
            CALIS: begin
               if (bitti) durum_d = BITTI;
            end
            BITTI: begin
               gecerli_d  = 1'b1;
               yaz_d      = bekleyen_yaz_q;
               rd_adres_d = bekleyen_rd_q;
               rd_deger_d = carp_bol_sonuc;
               durum_d    = BOSTA;
            end
            default: durum_d = BOSTA;
         endcase
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         durum_q        <= BOSTA;
         gecerli_q      <= 1'b0;
         yaz_q          <= 1'b0;
         rd_adres_q     <= '0;
         rd_deger_q     <= '0;
         bekleyen_rd_q  <= '0;
         bekleyen_yaz_q <= 1'b0;
      end else begin
         durum_q        <= durum_d;
         gecerli_q      <= gecerli_d;
         yaz_q          <= yaz_d;
         rd_adres_q     <= rd_adres_d;
         rd_deger_q     <= rd_deger_d;
         bekleyen_rd_q  <= bekleyen_rd_d;
         bekleyen_yaz_q <= bekleyen_yaz_d;
      end
   end

   assign gecerli_o    = gecerli_q;
   assign yaz_yazmac_o = yaz_q;
   assign rd_adres_o   = rd_adres_q;
   assign rd_deger_o   = rd_deger_q;

   yineli_carp_bol #(
      .VERI_BIT (VERI_BIT),
      .SAYAC_BIT(SAYAC_BIT)
   ) u_carp_bol (
      .clk   (clk_i),
      .rst   (rst_i),
      .basla (basla),
      .iptal (bosalt_i),
      .islem (islem_i),
      .deger1(deger1_i),
      .deger2(deger2_i),
      .bitti (bitti),
      .sonuc (carp_bol_sonuc)
   );

endmodule
